dmem_mmio_bridge: RTL

- Sits directly downstream of the processor's data-memory port, between the processor and the dmem RAM.
- Passes ordinary loads and stores to dmem.
- Decodes a small memory-mapped I/O window at the top of the 12-bit address space. The window holds a 32-bit transmit FIFO with a valid/ready drain port, a free-running cycle counter, and a compare timer with a sticky interrupt.
- Read data is returned with the same one-cycle registered latency as dmem, so the processor sees a uniform memory interface.

---
 rtl/dmem_mmio_bridge.sv | 83 ++++++++
 1 files changed

// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: routes processor data accesses to dmem or to an MMIO block (tx FIFO, cycle counter, compare timer)
module dmem_mmio_bridge #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [11:0] MMIO_BASE  = 12'hF00
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q_dmem,
   output logic [11:0] mem_address,
   output logic [31:0] mem_data,
   output logic        mem_wren,
   input  logic [31:0] mem_q,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        timer_irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [31:0]   fifo [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [31:0]   cycles, timer_cmp, snapshot, rd_val, status;
   logic [11:0]   offset;
   logic          mmio_hit, rd_hit, overflow, empty, full, pop, push, match;
   logic          wr_tx, wr_status, wr_cycles, wr_cmp, wr_ack;

   assign mmio_hit    = address_dmem >= MMIO_BASE;
   assign offset      = address_dmem - MMIO_BASE;
   assign mem_address = address_dmem;
   assign mem_data    = data;
   assign mem_wren    = wren & ~mmio_hit;

   assign wr_tx     = wren & mmio_hit & (offset == 12'd0);
   assign wr_status = wren & mmio_hit & (offset == 12'd1);
   assign wr_cycles = wren & mmio_hit & (offset == 12'd2);
   assign wr_cmp    = wren & mmio_hit & (offset == 12'd3);
   assign wr_ack    = wren & mmio_hit & (offset == 12'd4);

   assign empty    = count == '0;
   assign full     = count == (AW+1)'(FIFO_DEPTH);
   assign pop      = ~empty & tx_ready;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign push     = wr_tx & (~full | pop);
   assign tx_valid = ~empty;
   assign tx_data  = empty ? '0 : fifo[rd_ptr];
   assign match    = (timer_cmp != '0) & (cycles == timer_cmp);

   assign status = {23'b0, 5'(count), 1'b0, overflow, full, empty};
   assign rd_val = offset == 12'd1 ? status :
                   offset == 12'd2 ? cycles :
                   offset == 12'd3 ? timer_cmp :
                   offset == 12'd4 ? {31'b0, timer_irq} : '0;
   assign q_dmem = rd_hit ? snapshot : mem_q;

   always_ff @(posedge clock)
      if (push) fifo[wr_ptr] <= data;

   always_ff @(posedge clock)
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         cycles    <= '0;
         timer_cmp <= '0;
         timer_irq <= 1'b0;
         rd_hit    <= 1'b0;
         snapshot  <= '0;
      end else begin
         rd_hit    <= mmio_hit;
         snapshot  <= rd_val;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count     <= count + (AW+1)'(push) - (AW+1)'(pop);
         overflow  <= (wr_tx & full & ~pop) | (overflow & ~(wr_status & data[2]));
         cycles    <= wr_cycles ? data : cycles + 32'd1;
         timer_cmp <= wr_cmp ? data : timer_cmp;
         timer_irq <= match | (timer_irq & ~wr_ack);
      end
endmodule
